wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among three writers: the pipelined CPU's writeback result, the FPU result and the crypto-core result.
- Sits between the writeback cycle and the register file.
- Each accelerator result is latched in a one-entry holding buffer. A fixed priority scheme with aging decides which writer owns the port each cycle.
- Exports a pending-destination mask so the hazard unit can enforce write ordering.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width (8 registers).
- MAX_WAIT, 4, cycles a full buffer may be denied before it pre-empts the pipeline; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pipe_we  in  1  pipeline writeback request (RegWrite of the W stage).
- pipe_rd  in  ADDR_W  pipeline destination register.
- pipe_data  in  DATA_W  pipeline writeback result.
- wb_stall  out  1  W stage must hold pipe_* stable and retry next cycle.
- fpu_valid  in  1  FPU result offered.
- fpu_ready  out  1  FPU buffer can accept.
- fpu_rd  in  ADDR_W  FPU destination register.
- fpu_data  in  DATA_W  FPU result.
- cry_valid  in  1  crypto result offered.
- cry_ready  out  1  crypto buffer can accept.
- cry_rd  in  ADDR_W  crypto destination register.
- cry_data  in  DATA_W  crypto result.
- reg_we  out  1  register-file write enable.
- reg_waddr  out  ADDR_W  register-file write address.
- reg_wdata  out  DATA_W  register-file write data.
- grant_src  out  2  owner this cycle: 00 none, 01 pipe, 10 fpu, 11 cry.
- pending_mask  out  8  bit r set when a full buffer targets register r.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset clears:
  - both buffers (full=0), both age counters (0) and rr_ptr (0 = FPU preferred);
  - reg_we=0, wb_stall=0, grant_src=00, pending_mask=0.
- Ready signals during reset:
  - fpu_ready = ~fpu_full & ~rst; cry_ready likewise.
  - Ready is registered-state derived, never combinationally dependent on valid.
- Buffer accept:
  - The buffer latches rd/data on a clock edge where valid & ready.
  - A result accepted at edge N is eligible for grant from cycle N+1 onward. There is no same-cycle bypass.
- Buffer drain: the granted buffer clears full at the end of the grant cycle, so ready rises one cycle after the grant.
- Per-buffer age counter:
  - Increments (saturating at MAX_WAIT) each cycle the buffer is full and not granted.
  - Clears on grant.
  - The buffer is "starved" when age == MAX_WAIT.
- Grant priority, combinational from registered state plus pipe_we, evaluated in order:
  1. Starved buffer(s) first. If both are starved, rr_ptr picks.
  2. Otherwise pipe, if pipe_we.
  3. Otherwise full buffer(s). If both are full, rr_ptr picks.
  4. Otherwise none.
- rr_ptr: after any buffer grant, points to the other buffer.
- wb_stall = pipe_we & (grant_src != 01). A stalled pipe write is not lost. The W stage re-presents it, and it wins next cycle unless another buffer is starved.
- Write port:
  - reg_we=1 whenever grant_src != 00; reg_waddr/reg_wdata come from the granted source.
  - These outputs are combinational so pipeline writes keep zero added latency.
- pending_mask: OR of the decoded rd of every full buffer.
  - A buffer granted this cycle still shows in the mask this cycle and clears next cycle.
  - Same-rd ordering between writers is the hazard unit's job, using this mask. The arbiter never reorders or merges writes.
- Simultaneous events:
  - A buffer drained and a new valid offered in the same cycle: not accepted, because ready is still 0 that cycle; accepted next cycle.
  - Both buffers reach starved in the same cycle: rr_ptr winner writes, and the loser writes next cycle (still starved, beats pipe).
- Reset mid-operation: buffered results are discarded, and accelerators must re-issue. Outputs return to reset values immediately (asynchronous).

Decomposition:
- Shared package:
  - GRANT_NONE/PIPE/FPU/CRY encodings, DATA_W, ADDR_W defaults;
  - a decode function for the one-hot rd used by pending_mask.
- One natural sub-module, wb_hold_buf: one-entry buffer with valid/ready, rd/data latch and saturating age counter. Instantiated twice (fpu, cry).

Test Plan:
- Reset, then pipe_we=1, pipe_rd=3, pipe_data=0x1234 -> same cycle reg_we=1, waddr=3, wdata=0x1234, grant_src=01, wb_stall=0; fpu_ready=cry_ready=1.
- fpu_valid=1, rd=5, data=0xBEEF with pipe idle -> accepted at edge N, fpu_ready=0 and pending_mask=0x20 in cycle N+1, reg_we grant 10 in N+1, fpu_ready=1 in N+2.
- FPU buffer full and pipe_we held high continuously, MAX_WAIT=4 -> pipe granted 4 cycles. 5th cycle: grant_src=10, wb_stall=1. 6th cycle: pipe granted with its held value.
- Both buffers full, pipe idle, rr_ptr=0 -> fpu granted first, cry next cycle, then rr_ptr=0 (points to fpu).
- Both buffers starved simultaneously with pipe_we=1 -> two consecutive stall cycles, buffers drain in rr order, pipe written on the third cycle.
- rst asserted mid-cycle while both buffers are full -> reg_we, wb_stall, pending_mask drop to 0 immediately. After release, both ready=1 and no stale write occurs.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared encodings and helpers for the register-file write-port arbiter.
// Grant-source codes, default widths and the one-hot destination decode.
package wb_port_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_PIPE = 2'b01;
  localparam logic [1:0] GRANT_FPU  = 2'b10;
  localparam logic [1:0] GRANT_CRY  = 2'b11;

  function automatic logic [7:0] rd_onehot(input logic [ADDR_W_DEF-1:0] rd);
    logic [7:0] m;
    m     = '0;
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of writer-side and register-file-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              wb_stall;
  logic              fpu_valid;
  logic              fpu_ready;
  logic [ADDR_W-1:0] fpu_rd;
  logic [DATA_W-1:0] fpu_data;
  logic              cry_valid;
  logic              cry_ready;
  logic [ADDR_W-1:0] cry_rd;
  logic [DATA_W-1:0] cry_data;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_waddr;
  logic [DATA_W-1:0] reg_wdata;
  logic [1:0]        grant_src;
  logic [7:0]        pending_mask;

  modport slave (
    input  pipe_we, pipe_rd, pipe_data,
    input  fpu_valid, fpu_rd, fpu_data,
    input  cry_valid, cry_rd, cry_data,
    output wb_stall, fpu_ready, cry_ready,
    output reg_we, reg_waddr, reg_wdata, grant_src, pending_mask
  );

  modport master (
    output pipe_we, pipe_rd, pipe_data,
    output fpu_valid, fpu_rd, fpu_data,
    output cry_valid, cry_rd, cry_data,
    input  wb_stall, fpu_ready, cry_ready,
    input  reg_we, reg_waddr, reg_wdata, grant_src, pending_mask
  );
endinterface

// File: rtl/wb_port_arbiter_hold_buf.sv
// One-entry holding buffer for an accelerator result, with a saturating
// age counter that flags starvation after MAX_WAIT denied cycles.
module wb_hold_buf #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              grant,
  output logic              full,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] data,
  output logic              starved
);
  localparam logic [3:0] AGE_MAX = 4'(MAX_WAIT);

  logic              full_q, full_d;
  logic [3:0]        age_q, age_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      age_q  <= '0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      age_q  <= age_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  // Accept only while empty, so a drain and a new offer never overlap.
  always_comb begin
    full_d = full_q;
    age_d  = age_q;
    rd_d   = rd_q;
    data_d = data_q;
    if (grant) begin
      full_d = 1'b0;
      age_d  = '0;
    end else if (full_q) begin
      if (age_q != AGE_MAX) age_d = age_q + 4'd1;
    end else if (valid) begin
      full_d = 1'b1;
      age_d  = '0;
      rd_d   = rd_in;
      data_d = data_in;
    end
  end

  assign ready   = ~full_q & ~rst;
  assign full    = full_q;
  assign rd      = rd_q;
  assign data    = data_q;
  assign starved = full_q & (age_q == AGE_MAX);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback and two buffered accelerator results, with aging to bound waits.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);
  logic              fpu_full, fpu_starved, fpu_grant;
  logic              cry_full, cry_starved, cry_grant;
  logic [ADDR_W-1:0] fpu_rd, cry_rd;
  logic [DATA_W-1:0] fpu_data, cry_data;
  logic [1:0]        grant;
  logic              rr_q, rr_d;

  wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) u_fpu_buf (
    .clk(clk), .rst(rst), .valid(bus.fpu_valid), .ready(bus.fpu_ready),
    .rd_in(bus.fpu_rd), .data_in(bus.fpu_data), .grant(fpu_grant),
    .full(fpu_full), .rd(fpu_rd), .data(fpu_data), .starved(fpu_starved)
  );

  wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) u_cry_buf (
    .clk(clk), .rst(rst), .valid(bus.cry_valid), .ready(bus.cry_ready),
    .rd_in(bus.cry_rd), .data_in(bus.cry_data), .grant(cry_grant),
    .full(cry_full), .rd(cry_rd), .data(cry_data), .starved(cry_starved)
  );

  // rr_q = 0 prefers the FPU buffer on a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

  always_comb begin
    grant = GRANT_NONE;
    if (rst)                          grant = GRANT_NONE;
    else if (fpu_starved && cry_starved) grant = rr_q ? GRANT_CRY : GRANT_FPU;
    else if (fpu_starved)             grant = GRANT_FPU;
    else if (cry_starved)             grant = GRANT_CRY;
    else if (bus.pipe_we)             grant = GRANT_PIPE;
    else if (fpu_full && cry_full)    grant = rr_q ? GRANT_CRY : GRANT_FPU;
    else if (fpu_full)                grant = GRANT_FPU;
    else if (cry_full)                grant = GRANT_CRY;
  end

  assign fpu_grant = (grant == GRANT_FPU);
  assign cry_grant = (grant == GRANT_CRY);

  always_comb begin
    rr_d = rr_q;
    if (fpu_grant)      rr_d = 1'b1;
    else if (cry_grant) rr_d = 1'b0;
  end

  always_comb begin
    bus.reg_waddr = '0;
    bus.reg_wdata = '0;
    case (grant)
      GRANT_PIPE: begin bus.reg_waddr = bus.pipe_rd; bus.reg_wdata = bus.pipe_data; end
      GRANT_FPU:  begin bus.reg_waddr = fpu_rd;      bus.reg_wdata = fpu_data;      end
      GRANT_CRY:  begin bus.reg_waddr = cry_rd;      bus.reg_wdata = cry_data;      end
      default:    ;
    endcase
  end

  assign bus.reg_we       = (grant != GRANT_NONE);
  assign bus.grant_src    = grant;
  assign bus.wb_stall     = bus.pipe_we & ~rst & (grant != GRANT_PIPE);
  assign bus.pending_mask = (rd_onehot(ADDR_W_DEF'(fpu_rd)) & {8{fpu_full}})
                          | (rd_onehot(ADDR_W_DEF'(cry_rd)) & {8{cry_full}});

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter with MAX_WAIT = 4.
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_port_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  wb_port_arbiter #(.DATA_W(16), .ADDR_W(3), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] g, input logic stall,
                           input logic [2:0] addr, input logic [15:0] data);
    chk({tag, "_grant"}, 32'(bus.grant_src), 32'(g));
    chk({tag, "_we"}, 32'(bus.reg_we), 32'(g != 2'b00));
    chk({tag, "_stall"}, 32'(bus.wb_stall), 32'(stall));
    if (g != 2'b00) begin
      chk({tag, "_waddr"}, 32'(bus.reg_waddr), 32'(addr));
      chk({tag, "_wdata"}, 32'(bus.reg_wdata), 32'(data));
    end
  endtask

  initial begin
    bus.pipe_we = 0; bus.pipe_rd = 0; bus.pipe_data = 0;
    bus.fpu_valid = 0; bus.fpu_rd = 0; bus.fpu_data = 0;
    bus.cry_valid = 0; bus.cry_rd = 0; bus.cry_data = 0;

    // Reset state
    next_cycle(); next_cycle();
    chk("rst_we", 32'(bus.reg_we), 0);
    chk("rst_stall", 32'(bus.wb_stall), 0);
    chk("rst_grant", 32'(bus.grant_src), 0);
    chk("rst_mask", 32'(bus.pending_mask), 0);
    chk("rst_fpu_ready", 32'(bus.fpu_ready), 0);
    rst = 1'b0;
    #1;
    chk("rel_fpu_ready", 32'(bus.fpu_ready), 1);
    chk("rel_cry_ready", 32'(bus.cry_ready), 1);

    // Pipe write with zero latency
    bus.pipe_we = 1; bus.pipe_rd = 3; bus.pipe_data = 16'h1234;
    #1;
    chk_grant("pipe", 2'b01, 0, 3'd3, 16'h1234);
    bus.pipe_we = 0;

    // FPU accept, grant next cycle, drain and simultaneous re-offer
    bus.fpu_valid = 1; bus.fpu_rd = 5; bus.fpu_data = 16'hBEEF;
    next_cycle();
    bus.fpu_rd = 2; bus.fpu_data = 16'h0002;
    #1;
    chk("fpu_ready_full", 32'(bus.fpu_ready), 0);
    chk("fpu_mask", 32'(bus.pending_mask), 32'h20);
    chk_grant("fpu1", 2'b10, 0, 3'd5, 16'hBEEF);
    next_cycle();
    chk("fpu_ready_again", 32'(bus.fpu_ready), 1);
    chk("fpu_mask_clr", 32'(bus.pending_mask), 0);
    chk_grant("fpu_idle", 2'b00, 0, 3'd0, 16'h0);
    next_cycle();
    bus.fpu_valid = 0;
    #1;
    chk("fpu_mask2", 32'(bus.pending_mask), 32'h04);
    chk_grant("fpu2", 2'b10, 0, 3'd2, 16'h0002);
    next_cycle();
    chk_grant("fpu_drained", 2'b00, 0, 3'd0, 16'h0);

    // Aging: FPU full, pipe held high
    bus.fpu_valid = 1; bus.fpu_rd = 6; bus.fpu_data = 16'h6666;
    next_cycle();
    bus.fpu_valid = 0; bus.pipe_we = 1; bus.pipe_rd = 1;
    for (int i = 0; i < 4; i++) begin
      bus.pipe_data = 16'h1000 + 16'(i);
      #1;
      chk_grant("age_pipe", 2'b01, 0, 3'd1, 16'h1000 + 16'(i));
      next_cycle();
    end
    bus.pipe_data = 16'h2000;
    #1;
    chk_grant("age_fpu", 2'b10, 1, 3'd6, 16'h6666);
    next_cycle();
    chk_grant("age_pipe_retry", 2'b01, 0, 3'd1, 16'h2000);
    bus.pipe_we = 0;

    // Both full, pipe idle, rr starts at FPU
    do_reset();
    bus.fpu_valid = 1; bus.fpu_rd = 1; bus.fpu_data = 16'h1111;
    bus.cry_valid = 1; bus.cry_rd = 7; bus.cry_data = 16'h7777;
    next_cycle();
    bus.fpu_valid = 0; bus.cry_valid = 0;
    #1;
    chk("both_mask", 32'(bus.pending_mask), 32'h82);
    chk_grant("rr_fpu", 2'b10, 0, 3'd1, 16'h1111);
    next_cycle();
    chk("both_mask2", 32'(bus.pending_mask), 32'h80);
    chk_grant("rr_cry", 2'b11, 0, 3'd7, 16'h7777);
    next_cycle();
    chk_grant("rr_none", 2'b00, 0, 3'd0, 16'h0);
    bus.fpu_valid = 1; bus.fpu_rd = 4; bus.fpu_data = 16'h4444;
    bus.cry_valid = 1; bus.cry_rd = 0; bus.cry_data = 16'h0C0C;
    next_cycle();
    bus.fpu_valid = 0; bus.cry_valid = 0;
    #1;
    chk_grant("rr_back_fpu", 2'b10, 0, 3'd4, 16'h4444);
    next_cycle();
    chk_grant("rr_back_cry", 2'b11, 0, 3'd0, 16'h0C0C);
    next_cycle();

    // Both starved at once while pipe keeps requesting
    bus.fpu_valid = 1; bus.fpu_rd = 2; bus.fpu_data = 16'hAAAA;
    bus.cry_valid = 1; bus.cry_rd = 3; bus.cry_data = 16'hCCCC;
    bus.pipe_we = 1; bus.pipe_rd = 6; bus.pipe_data = 16'h5555;
    #1;
    chk_grant("st_load_pipe", 2'b01, 0, 3'd6, 16'h5555);
    next_cycle();
    bus.fpu_valid = 0; bus.cry_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_grant("st_pipe", 2'b01, 0, 3'd6, 16'h5555);
      next_cycle();
    end
    chk_grant("st_fpu", 2'b10, 1, 3'd2, 16'hAAAA);
    next_cycle();
    chk_grant("st_cry", 2'b11, 1, 3'd3, 16'hCCCC);
    next_cycle();
    chk_grant("st_pipe_done", 2'b01, 0, 3'd6, 16'h5555);
    bus.pipe_we = 0;

    // Asynchronous reset while both buffers are full
    bus.fpu_valid = 1; bus.fpu_rd = 5; bus.fpu_data = 16'h0505;
    bus.cry_valid = 1; bus.cry_rd = 6; bus.cry_data = 16'h0606;
    next_cycle();
    bus.fpu_valid = 0; bus.cry_valid = 0;
    #1;
    chk("pre_rst_mask", 32'(bus.pending_mask), 32'h60);
    #2;
    bus.pipe_we = 1;
    rst = 1'b1;
    #1;
    chk("async_we", 32'(bus.reg_we), 0);
    chk("async_stall", 32'(bus.wb_stall), 0);
    chk("async_mask", 32'(bus.pending_mask), 0);
    chk("async_grant", 32'(bus.grant_src), 0);
    next_cycle();
    bus.pipe_we = 0;
    rst = 1'b0;
    #1;
    chk("post_fpu_ready", 32'(bus.fpu_ready), 1);
    chk("post_cry_ready", 32'(bus.cry_ready), 1);
    chk_grant("post_no_write", 2'b00, 0, 3'd0, 16'h0);
    next_cycle();
    chk_grant("post_no_write2", 2'b00, 0, 3'd0, 16'h0);
    chk("post_mask", 32'(bus.pending_mask), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
